quad_step_decoder: RTL

Front-end stage that turns a two-phase quadrature encoder (channels A/B, asynchronous to clk) into the one-cycle `step` pulse and `dir` level that drive the enable and up/down inputs of the up/down counter directly downstream. It synchronises and glitch-filters both channels, decodes every Gray-code edge (x4 decoding) and flags illegal double transitions. Output is registered, so it connects straight to the counter with no glue logic.

---
 rtl/quad_step_decoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronise, glitch-filter, x4 Gray decode into a registered
// step pulse plus dir level for a downstream up/down counter, with a sticky illegal-move flag.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a_in,
    input  logic b_in,
    input  logic err_clr,
    output logic step,
    output logic dir,
    output logic err,
    output logic busy
);

    function automatic int clogb2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    localparam int CW         = clogb2(FILTER_LEN) + 1;
    localparam int SETTLE_CYC = SYNC_STAGES + FILTER_LEN;
    localparam int SW         = $clog2(SETTLE_CYC + 1);

    localparam logic [CW-1:0] FILT_LAST   = CW'(FILTER_LEN - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic {SETTLE, RUN} state_t;

    // Forward neighbour in the up sequence {B,A}: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] fwd_next(input logic [1:0] x);
        logic [1:0] r;
        case (x)
            2'b00:   r = 2'b01;
            2'b01:   r = 2'b11;
            2'b11:   r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [SYNC_STAGES-1:0]  a_sync_q, a_sync_d;
    logic [SYNC_STAGES-1:0]  b_sync_q, b_sync_d;
    logic [1:0]              filt_q, filt_d;
    logic [1:0][CW-1:0]      cnt_q, cnt_d;
    logic [1:0]              prev_q, prev_d;
    logic                    step_q, step_d;
    logic                    dir_q, dir_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic [1:0]              x_s;

    assign x_s = {b_sync_q[SYNC_STAGES-1], a_sync_q[SYNC_STAGES-1]};

    always_comb begin
        a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a_in};
        b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b_in};
        state_d  = state_q;
        settle_d = settle_q;
        filt_d   = filt_q;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        err_d    = err_q;
        busy_d   = (state_q == SETTLE);

        if (err_clr) err_d = 1'b0;

        case (state_q)
            SETTLE: begin
                // Track inputs unfiltered; prev takes the same value so release levels never step
                filt_d = x_s;
                cnt_d  = '0;
                if (settle_q == SETTLE_LAST) begin
                    state_d  = RUN;
                    prev_d   = x_s;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            default: begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (x_s[ch] == filt_q[ch]) begin
                        cnt_d[ch] = '0;
                    end else if (cnt_q[ch] == FILT_LAST) begin
                        filt_d[ch] = x_s[ch];
                        cnt_d[ch]  = '0;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CW'(1);
                    end
                end

                prev_d = filt_q;
                if (filt_q != prev_q) begin
                    if ((filt_q ^ prev_q) == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        step_d = 1'b1;
                        dir_d  = (filt_q == fwd_next(prev_q));
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            a_sync_q <= '0;
            b_sync_q <= '0;
            filt_q   <= '0;
            cnt_q    <= '0;
            prev_q   <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b1;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            a_sync_q <= a_sync_d;
            b_sync_q <= b_sync_d;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule
